// File: rtl/multi_cycle_control.sv
// Multi-cycle MIPS-style main control unit.
// A 13-state FSM sequences fetch, decode, address/execute, memory and
// write-back steps. The opcode/funct inputs come straight from the
// instruction register, so they stay stable from DECODE to the end of the
// instruction. That lets later states re-decode them to choose lw vs sw,
// beq vs bne, j vs jal and addi vs the extended immediate ops.

module multi_cycle_control #(
   parameter int ALUOP_W = 2,   // ALUOp width, bits above [1:0] are driven 0
   parameter int EXT_IMM = 0    // nonzero enables slti/andi/ori
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [5:0]         opcode,
   input  logic [5:0]         funct,
   input  logic               zero,
   input  logic               mem_ready,
   output logic               PCWrite,
   output logic               IorD,
   output logic               MemRead,
   output logic               MemWrite,
   output logic               IRWrite,
   output logic               RegWrite,
   output logic               RegDst,
   output logic               MemtoReg,
   output logic               Jal,
   output logic               ALUSrcA,
   output logic [1:0]         ALUSrcB,
   output logic [1:0]         PCSource,
   output logic [ALUOP_W-1:0] ALUOp,
   output logic [3:0]         state,
   output logic               illegal
);

   // ------------------------------------------------------------------
   // State encoding (codes 13-15 are unused and recover to FETCH)
   // ------------------------------------------------------------------
   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXEC   = 4'd6,
      S_RWB    = 4'd7,
      S_BRANCH = 4'd8,
      S_JUMP   = 4'd9,
      S_IMMEXE = 4'd10,
      S_IMMWB  = 4'd11,
      S_JR     = 4'd12
   } state_t;

   // Opcodes and the jr function code
   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] FN_JR    = 6'h08;

   // ALUSrcB selections
   localparam logic [1:0] SRCB_REG    = 2'b00;
   localparam logic [1:0] SRCB_FOUR   = 2'b01;
   localparam logic [1:0] SRCB_IMM    = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH = 2'b11;

   // PCSource selections
   localparam logic [1:0] PC_ALU    = 2'b00;
   localparam logic [1:0] PC_ALUOUT = 2'b01;
   localparam logic [1:0] PC_JUMP   = 2'b10;
   localparam logic [1:0] PC_RS     = 2'b11;

   // ALU operation classes
   localparam logic [1:0] ALU_ADD   = 2'b00;
   localparam logic [1:0] ALU_SUB   = 2'b01;
   localparam logic [1:0] ALU_FUNCT = 2'b10;
   localparam logic [1:0] ALU_IMM   = 2'b11;

   state_t     state_q;
   state_t     state_d;
   logic [1:0] alu_op;

   // ------------------------------------------------------------------
   // Instruction classification from the held instruction register
   // ------------------------------------------------------------------
   logic is_lw, is_sw, is_rtype, is_jr, is_beq, is_bne, is_j, is_jal;
   logic is_addi, is_ext_imm, is_imm, is_legal;

   assign is_lw      = (opcode == OP_LW);
   assign is_sw      = (opcode == OP_SW);
   assign is_rtype   = (opcode == OP_RTYPE);
   assign is_jr      = is_rtype && (funct == FN_JR);
   assign is_beq     = (opcode == OP_BEQ);
   assign is_bne     = (opcode == OP_BNE);
   assign is_j       = (opcode == OP_J);
   assign is_jal     = (opcode == OP_JAL);
   assign is_addi    = (opcode == OP_ADDI);
   // The logical/compare immediates exist only when the option is built in
   assign is_ext_imm = (EXT_IMM != 0) &&
                       ((opcode == OP_SLTI) || (opcode == OP_ANDI) || (opcode == OP_ORI));
   assign is_imm     = is_addi || is_ext_imm;
   assign is_legal   = is_lw || is_sw || is_rtype || is_beq || is_bne ||
                       is_j || is_jal || is_imm;

   // ------------------------------------------------------------------
   // State register: reset wins from any state, including a memory wait
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      // NOTE: sequential state is updated with non-blocking assignments so
      // every flop samples the pre-edge values, independent of block order.
      if (rst) begin
         state_q <= S_FETCH;
      end else begin
         state_q <= state_d;
      end
   end

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      // NOTE: assigning a default before the case keeps every path driven,
      // so no latch is inferred for paths the case does not mention.
      state_d = S_FETCH;
      case (state_q)
         S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
         S_DECODE: begin
            if (is_lw || is_sw) begin
               state_d = S_MEMADR;
            end else if (is_jr) begin
               state_d = S_JR;
            end else if (is_rtype) begin
               state_d = S_EXEC;
            end else if (is_beq || is_bne) begin
               state_d = S_BRANCH;
            end else if (is_j || is_jal) begin
               state_d = S_JUMP;
            end else if (is_imm) begin
               state_d = S_IMMEXE;
            end else begin
               state_d = S_FETCH;   // undecodable: abandon and refetch
            end
         end
         S_MEMADR: state_d = is_lw ? S_MEMRD : S_MEMWR;
         S_MEMRD:  state_d = mem_ready ? S_MEMWB : S_MEMRD;
         S_MEMWB:  state_d = S_FETCH;
         S_MEMWR:  state_d = mem_ready ? S_FETCH : S_MEMWR;
         S_EXEC:   state_d = S_RWB;
         S_RWB:    state_d = S_FETCH;
         S_BRANCH: state_d = S_FETCH;
         S_JUMP:   state_d = S_FETCH;
         S_IMMEXE: state_d = S_IMMWB;
         S_IMMWB:  state_d = S_FETCH;
         S_JR:     state_d = S_FETCH;
         default:  state_d = S_FETCH;
      endcase
   end

   // ------------------------------------------------------------------
   // Output decode: Moore outputs plus the gated PCWrite/IRWrite terms,
   // all forced low while reset is held
   // ------------------------------------------------------------------
   always_comb begin
      PCWrite  = 1'b0;
      IorD     = 1'b0;
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      IRWrite  = 1'b0;
      RegWrite = 1'b0;
      RegDst   = 1'b0;
      MemtoReg = 1'b0;
      Jal      = 1'b0;
      ALUSrcA  = 1'b0;
      ALUSrcB  = SRCB_REG;
      PCSource = PC_ALU;
      alu_op   = ALU_ADD;
      illegal  = 1'b0;

      case (state_q)
         S_FETCH: begin
            // PC+4 and the instruction latch only commit once memory answers
            MemRead  = 1'b1;
            ALUSrcB  = SRCB_FOUR;
            IRWrite  = mem_ready;
            PCWrite  = mem_ready;
         end
         S_DECODE: begin
            // Precompute the branch target into ALUOut
            ALUSrcB  = SRCB_IMM_SH;
            illegal  = !is_legal;
         end
         S_MEMADR: begin
            ALUSrcA  = 1'b1;
            ALUSrcB  = SRCB_IMM;
         end
         S_MEMRD: begin
            MemRead  = 1'b1;
            IorD     = 1'b1;
         end
         S_MEMWB: begin
            RegWrite = 1'b1;
            MemtoReg = 1'b1;
         end
         S_MEMWR: begin
            MemWrite = 1'b1;
            IorD     = 1'b1;
         end
         S_EXEC: begin
            ALUSrcA  = 1'b1;
            alu_op   = ALU_FUNCT;
         end
         S_RWB: begin
            RegWrite = 1'b1;
            RegDst   = 1'b1;
         end
         S_BRANCH: begin
            ALUSrcA  = 1'b1;
            alu_op   = ALU_SUB;
            PCSource = PC_ALUOUT;
            PCWrite  = (is_beq && zero) || (is_bne && !zero);
         end
         S_JUMP: begin
            // jal links $31 with PC+4 through the Jal mux
            PCWrite  = 1'b1;
            PCSource = PC_JUMP;
            Jal      = is_jal;
            RegWrite = is_jal;
         end
         S_IMMEXE: begin
            ALUSrcA  = 1'b1;
            ALUSrcB  = SRCB_IMM;
            alu_op   = is_ext_imm ? ALU_IMM : ALU_ADD;
         end
         S_IMMWB: begin
            RegWrite = 1'b1;
         end
         S_JR: begin
            PCWrite  = 1'b1;
            PCSource = PC_RS;
         end
         default: begin
            // unused codes: everything stays at its default of 0
         end
      endcase

      if (rst) begin
         PCWrite  = 1'b0;
         IorD     = 1'b0;
         MemRead  = 1'b0;
         MemWrite = 1'b0;
         IRWrite  = 1'b0;
         RegWrite = 1'b0;
         RegDst   = 1'b0;
         MemtoReg = 1'b0;
         Jal      = 1'b0;
         ALUSrcA  = 1'b0;
         ALUSrcB  = 2'b00;
         PCSource = 2'b00;
         alu_op   = 2'b00;
         illegal  = 1'b0;
      end
   end

   // Zero-extend the 2-bit ALU class to the configured port width
   assign ALUOp = ALUOP_W'(alu_op);

   // Report the current state, held at 0 while reset is asserted
   assign state = rst ? 4'd0 : state_q;

endmodule

// File: tb/tb_multi_cycle_control.sv
// Directed-vector bench for multi_cycle_control.
// Two instances share the stimulus: one with default parameters and one
// with EXT_IMM=1 and a 3-bit ALUOp, so the extended immediate decode and
// the zero upper ALUOp bit are both observed.

module tb_multi_cycle_control;

   logic       clk = 1'b0;
   logic       rst;
   logic [5:0] opcode;
   logic [5:0] funct;
   logic       zero;
   logic       mem_ready;

   // Instance 0 outputs (EXT_IMM=0, ALUOP_W=2)
   logic       d0_pcwrite, d0_iord, d0_memread, d0_memwrite, d0_irwrite;
   logic       d0_regwrite, d0_regdst, d0_memtoreg, d0_jal, d0_alusrca;
   logic [1:0] d0_alusrcb, d0_pcsource, d0_aluop;
   logic [3:0] d0_state;
   logic       d0_illegal;

   // Instance 1 outputs (EXT_IMM=1, ALUOP_W=3)
   logic       d1_pcwrite, d1_iord, d1_memread, d1_memwrite, d1_irwrite;
   logic       d1_regwrite, d1_regdst, d1_memtoreg, d1_jal, d1_alusrca;
   logic [1:0] d1_alusrcb, d1_pcsource;
   logic [2:0] d1_aluop;
   logic [3:0] d1_state;
   logic       d1_illegal;

   int vectors     = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   multi_cycle_control #(.ALUOP_W(2), .EXT_IMM(0)) dut0 (
      .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
      .mem_ready(mem_ready),
      .PCWrite(d0_pcwrite), .IorD(d0_iord), .MemRead(d0_memread),
      .MemWrite(d0_memwrite), .IRWrite(d0_irwrite), .RegWrite(d0_regwrite),
      .RegDst(d0_regdst), .MemtoReg(d0_memtoreg), .Jal(d0_jal),
      .ALUSrcA(d0_alusrca), .ALUSrcB(d0_alusrcb), .PCSource(d0_pcsource),
      .ALUOp(d0_aluop), .state(d0_state), .illegal(d0_illegal)
   );

   multi_cycle_control #(.ALUOP_W(3), .EXT_IMM(1)) dut1 (
      .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
      .mem_ready(mem_ready),
      .PCWrite(d1_pcwrite), .IorD(d1_iord), .MemRead(d1_memread),
      .MemWrite(d1_memwrite), .IRWrite(d1_irwrite), .RegWrite(d1_regwrite),
      .RegDst(d1_regdst), .MemtoReg(d1_memtoreg), .Jal(d1_jal),
      .ALUSrcA(d1_alusrca), .ALUSrcB(d1_alusrcb), .PCSource(d1_pcsource),
      .ALUOp(d1_aluop), .state(d1_state), .illegal(d1_illegal)
   );

   // Control word layout:
   // {PCWrite,IorD,MemRead,MemWrite,IRWrite,RegWrite,RegDst,MemtoReg,Jal,
   //  ALUSrcA,ALUSrcB[1:0],PCSource[1:0],ALUOp[2:0],illegal}
   logic [17:0] ctl0, ctl1;
   assign ctl0 = {d0_pcwrite, d0_iord, d0_memread, d0_memwrite, d0_irwrite,
                  d0_regwrite, d0_regdst, d0_memtoreg, d0_jal, d0_alusrca,
                  d0_alusrcb, d0_pcsource, {1'b0, d0_aluop}, d0_illegal};
   assign ctl1 = {d1_pcwrite, d1_iord, d1_memread, d1_memwrite, d1_irwrite,
                  d1_regwrite, d1_regdst, d1_memtoreg, d1_jal, d1_alusrca,
                  d1_alusrcb, d1_pcsource, d1_aluop, d1_illegal};

   function automatic logic [17:0] cw(
      input logic pcw, input logic iord, input logic mr, input logic mw,
      input logic irw, input logic rw, input logic rd, input logic m2r,
      input logic jal, input logic srca, input logic [1:0] srcb,
      input logic [1:0] pcsrc, input logic [2:0] aop, input logic ill);
      return {pcw, iord, mr, mw, irw, rw, rd, m2r, jal, srca, srcb, pcsrc, aop, ill};
   endfunction

   //                              pcw iord mr mw irw rw rd m2r jal srca srcb   pcsrc  aop     ill
   localparam logic [17:0] E_ZERO       = 18'd0;
   localparam logic [17:0] E_FETCH      = cw(1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 2'b01, 2'b00, 3'b000, 0);
   localparam logic [17:0] E_FETCH_WAIT = cw(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 3'b000, 0);
   localparam logic [17:0] E_DECODE     = cw(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 3'b000, 0);
   localparam logic [17:0] E_DECODE_ILL = cw(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 3'b000, 1);
   localparam logic [17:0] E_MEMADR     = cw(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 3'b000, 0);
   localparam logic [17:0] E_MEMRD      = cw(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b000, 0);
   localparam logic [17:0] E_MEMWB      = cw(0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 2'b00, 2'b00, 3'b000, 0);
   localparam logic [17:0] E_MEMWR      = cw(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b000, 0);
   localparam logic [17:0] E_EXEC       = cw(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 3'b010, 0);
   localparam logic [17:0] E_RWB        = cw(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 2'b00, 2'b00, 3'b000, 0);
   localparam logic [17:0] E_BR_TAKEN   = cw(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 3'b001, 0);
   localparam logic [17:0] E_BR_NOT     = cw(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 3'b001, 0);
   localparam logic [17:0] E_JAL        = cw(1, 0, 0, 0, 0, 1, 0, 0, 1, 0, 2'b00, 2'b10, 3'b000, 0);
   localparam logic [17:0] E_J          = cw(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 3'b000, 0);
   localparam logic [17:0] E_JR         = cw(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b11, 3'b000, 0);
   localparam logic [17:0] E_IMM_ADD    = cw(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 3'b000, 0);
   localparam logic [17:0] E_IMM_EXT    = cw(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 3'b011, 0);
   localparam logic [17:0] E_IMMWB      = cw(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 3'b000, 0);

   task automatic check(input string tag, input logic [31:0] observed,
                        input logic [31:0] expected);
      vectors++;
      if (observed !== expected) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Check both instances for the current cycle, then advance one clock.
   // Inputs are set just after a rising edge; outputs are sampled 1 ns later.
   task automatic cyc2(input string tag,
                       input logic [3:0] s0, input logic [17:0] e0,
                       input logic [3:0] s1, input logic [17:0] e1);
      #1;
      check({tag, "/state0"}, d0_state, s0);
      check({tag, "/ctl0"},   ctl0,     e0);
      check({tag, "/state1"}, d1_state, s1);
      check({tag, "/ctl1"},   ctl1,     e1);
      @(posedge clk);
      #1;
   endtask

   task automatic cyc(input string tag, input logic [3:0] s, input logic [17:0] e);
      cyc2(tag, s, e, s, e);
   endtask

   initial begin
      rst       = 1'b1;
      opcode    = 6'h23;
      funct     = 6'h00;
      zero      = 1'b0;
      mem_ready = 1'b1;
      @(posedge clk);
      #1;
      cyc("reset_hold", 4'd0, E_ZERO);
      rst = 1'b0;

      // lw with memory always ready: 0,1,2,3,4 then FETCH
      cyc("lw_fetch",  4'd0, E_FETCH);
      cyc("lw_decode", 4'd1, E_DECODE);
      cyc("lw_memadr", 4'd2, E_MEMADR);
      cyc("lw_memrd",  4'd3, E_MEMRD);
      cyc("lw_memwb",  4'd4, E_MEMWB);

      // sw, with one fetch stall and three write wait cycles
      opcode    = 6'h2B;
      mem_ready = 1'b0;
      cyc("sw_fetch_wait", 4'd0, E_FETCH_WAIT);
      mem_ready = 1'b1;
      cyc("sw_fetch",  4'd0, E_FETCH);
      cyc("sw_decode", 4'd1, E_DECODE);
      cyc("sw_memadr", 4'd2, E_MEMADR);
      mem_ready = 1'b0;
      for (int i = 0; i < 3; i++) cyc("sw_memwr_wait", 4'd5, E_MEMWR);
      mem_ready = 1'b1;
      cyc("sw_memwr_done", 4'd5, E_MEMWR);

      // R-type add
      opcode = 6'h00;
      funct  = 6'h20;
      cyc("add_fetch",  4'd0, E_FETCH);
      cyc("add_decode", 4'd1, E_DECODE);
      cyc("add_exec",   4'd6, E_EXEC);
      cyc("add_rwb",    4'd7, E_RWB);

      // beq with zero=1 is taken
      opcode = 6'h04;
      zero   = 1'b1;
      cyc("beq_fetch",  4'd0, E_FETCH);
      cyc("beq_decode", 4'd1, E_DECODE);
      cyc("beq_branch", 4'd8, E_BR_TAKEN);

      // bne with zero=1 is not taken
      opcode = 6'h05;
      cyc("bne_fetch",  4'd0, E_FETCH);
      cyc("bne_decode", 4'd1, E_DECODE);
      cyc("bne_branch_z1", 4'd8, E_BR_NOT);

      // bne with zero=0 is taken
      zero = 1'b0;
      cyc("bne2_fetch",  4'd0, E_FETCH);
      cyc("bne2_decode", 4'd1, E_DECODE);
      cyc("bne_branch_z0", 4'd8, E_BR_TAKEN);

      // jal, then j, then jr
      opcode = 6'h03;
      cyc("jal_fetch",  4'd0, E_FETCH);
      cyc("jal_decode", 4'd1, E_DECODE);
      cyc("jal_jump",   4'd9, E_JAL);
      opcode = 6'h02;
      cyc("j_fetch",  4'd0, E_FETCH);
      cyc("j_decode", 4'd1, E_DECODE);
      cyc("j_jump",   4'd9, E_J);
      opcode = 6'h00;
      funct  = 6'h08;
      cyc("jr_fetch",  4'd0, E_FETCH);
      cyc("jr_decode", 4'd1, E_DECODE);
      cyc("jr_jr",     4'd12, E_JR);

      // addi uses the add ALU class in both builds
      opcode = 6'h08;
      funct  = 6'h00;
      cyc("addi_fetch",  4'd0, E_FETCH);
      cyc("addi_decode", 4'd1, E_DECODE);
      cyc("addi_exe",    4'd10, E_IMM_ADD);
      cyc("addi_wb",     4'd11, E_IMMWB);

      // andi: illegal without EXT_IMM, immediate-logic with it
      opcode = 6'h0C;
      cyc("andi_fetch", 4'd0, E_FETCH);
      cyc2("andi_decode", 4'd1, E_DECODE_ILL, 4'd1,  E_DECODE);
      cyc2("andi_exe",    4'd0, E_FETCH,      4'd10, E_IMM_EXT);
      cyc2("andi_wb",     4'd1, E_DECODE_ILL, 4'd11, E_IMMWB);

      // Unknown opcode is illegal in both builds
      opcode = 6'h3F;
      cyc("bad_fetch",  4'd0, E_FETCH);
      cyc("bad_decode", 4'd1, E_DECODE_ILL);
      cyc("bad_refetch", 4'd0, E_FETCH);

      // Reset during a stalled lw memory read
      opcode = 6'h23;
      cyc("rlw_decode", 4'd1, E_DECODE);
      cyc("rlw_memadr", 4'd2, E_MEMADR);
      mem_ready = 1'b0;
      cyc("rlw_memrd_wait", 4'd3, E_MEMRD);
      cyc("rlw_memrd_hold", 4'd3, E_MEMRD);
      rst = 1'b1;
      cyc("rst_in_memrd",   4'd0, E_ZERO);
      cyc("rst_after_edge", 4'd0, E_ZERO);
      rst = 1'b0;
      cyc("rst_release_fetch", 4'd0, E_FETCH_WAIT);
      mem_ready = 1'b1;
      cyc("resume_fetch",  4'd0, E_FETCH);
      cyc("resume_decode", 4'd1, E_DECODE);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
